// File: rtl/div_32_arbiter.sv
// Round-robin arbiter and sequencer sharing one divider among P_NUM_REQ requesters.
// Exactly one division is outstanding: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module div_32_arbiter #(
    parameter int unsigned P_WIDTH   = 32,
    parameter int unsigned P_NUM_REQ = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [P_NUM_REQ-1:0]         req_valid,
    output logic [P_NUM_REQ-1:0]         req_ready,
    input  logic [P_NUM_REQ*P_WIDTH-1:0] req_dividend,
    input  logic [P_NUM_REQ*P_WIDTH-1:0] req_divisor,
    output logic [P_NUM_REQ-1:0]         rsp_valid,
    input  logic [P_NUM_REQ-1:0]         rsp_ready,
    output logic [P_WIDTH-1:0]           rsp_quotient,
    output logic [P_WIDTH-1:0]           rsp_remainder,
    output logic                         div_start,
    output logic [P_WIDTH-1:0]           div_dividend,
    output logic [P_WIDTH-1:0]           div_divisor,
    input  logic [P_WIDTH-1:0]           div_quotient,
    input  logic [P_WIDTH-1:0]           div_remainder,
    input  logic                         div_done,
    output logic                         busy
);
    localparam int unsigned ID_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
    localparam int unsigned CW   = ID_W + 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(P_NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   sel_id;
    logic              sel_found;
    logic [CW-1:0]     cand;
    logic [P_WIDTH-1:0] sel_dividend;
    logic [P_WIDTH-1:0] sel_divisor;

    // Rotating-priority search: first valid requester at or after ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < P_NUM_REQ; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(P_NUM_REQ)) begin
                cand = cand - CW'(P_NUM_REQ);
            end
            if (!sel_found && req_valid[cand[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
            if (sel_id == ID_W'(i)) begin
                sel_dividend = req_dividend[i*P_WIDTH +: P_WIDTH];
                sel_divisor  = req_divisor[i*P_WIDTH +: P_WIDTH];
            end
        end
    end

    // Handshake strobes are forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (rst_n && (state == IDLE) && sel_found) begin
            req_ready[sel_id] = 1'b1;
        end
        if (rst_n && (state == RESP)) begin
            rsp_valid[gnt_id] = 1'b1;
        end
    end

    assign busy = rst_n && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            gnt_id        <= '0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        gnt_id       <= sel_id;
                        div_start    <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    // Only the granted requester's accept completes the response.
                    if (rsp_ready[gnt_id]) begin
                        ptr   <= (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_32_arbiter.sv
// Self-checking bench for div_32_arbiter with a behavioural div_32 stand-in.
module tb_div_32_arbiter;
    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_quotient;
    logic [W-1:0]   rsp_remainder;
    logic           div_start;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic [W-1:0]   div_quotient;
    logic [W-1:0]   div_remainder;
    logic           div_done;
    logic           busy;

    logic [W-1:0]   op_a [N];
    logic [W-1:0]   op_b [N];
    logic           stray;
    logic           keep_valid;
    logic [N-1:0]   drop_mask;
    int unsigned    hs_count;
    int unsigned    cyc;
    int unsigned    checks;
    int unsigned    errors;
    exp_t           sb [$];
    vec_t           vecs [5];
    vec_t           last_vec;

    assign req_dividend = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_divisor  = {op_b[3], op_b[2], op_b[1], op_b[0]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: done 36 cycles after start, 2 cycles for a zero divisor.
    logic        m_busy;
    logic [5:0]  m_cnt;
    logic [31:0] m_q;
    logic [31:0] m_r;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= (div_divisor == 0) ? 6'd1 : 6'd35;
            if (div_divisor == 0) begin
                m_q <= '1;
                m_r <= div_dividend;
            end else begin
                m_q <= div_dividend / div_divisor;
                m_r <= div_dividend % div_divisor;
            end
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 6'd1;
        end
    end
    assign div_done      = (m_busy && (m_cnt == 0)) || stray;
    assign div_quotient  = stray ? 32'hDEADBEEF : m_q;
    assign div_remainder = stray ? 32'hDEADBEEF : m_r;

    div_32_arbiter #(.P_WIDTH(W), .P_NUM_REQ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample on the falling edge; also acts as the response-side scoreboard monitor.
    task automatic at_neg();
        exp_t        e;
        logic [1:0]  rid;
        @(negedge clk);
        if (!keep_valid) drop_mask |= req_ready & req_valid;
        hs_count += $countones(req_ready & req_valid);
        if (rst_n) begin
            chk("onehot", 32'(($countones(req_ready) <= 1) && ($countones(rsp_valid) <= 1)), 32'd1);
            if ((rsp_valid & rsp_ready) != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
                end else begin
                    e   = sb.pop_front();
                    rid = '0;
                    for (int i = 0; i < N; i++) if (rsp_valid[i]) rid = 2'(i);
                    chk("rsp_id", 32'(rid), 32'(e.id));
                    chk("rsp_quotient", rsp_quotient, e.q);
                    chk("rsp_remainder", rsp_remainder, e.r);
                end
            end
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~drop_mask;
        drop_mask = '0;
    endtask

    task automatic wait_grant(input logic [1:0] id, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            at_neg();
            if (req_ready[id]) begin
                ok = 1'b1;
                return;
            end
            at_pos();
        end
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (sb.size() == 0) break;
            at_neg();
            at_pos();
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned t;
        bit          ok;
        op_a[v.id] = v.a;
        op_b[v.id] = v.b;
        sb.push_back('{v.id, v.q, v.r});
        req_valid[v.id] = 1'b1;
        wait_grant(v.id, ok);
        chk("grant", 32'(ok), 32'd1);
        if (!ok) begin
            req_valid = '0;
            at_pos();
            return;
        end
        t = cyc;
        chk("req_ready", 32'(req_ready), 32'(4'b0001 << v.id));
        at_pos();
        at_neg();
        chk("div_start", 32'(div_start), 32'd1);
        chk("div_dividend", div_dividend, v.a);
        chk("div_divisor", div_divisor, v.b);
        at_pos();
        at_neg();
        chk("div_start_pulse", 32'(div_start), 32'd0);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            at_pos();
            at_neg();
            if (rsp_valid[v.id]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rsp_seen", 32'(ok), 32'd1);
        chk("rsp_latency", cyc - t, v.lat);
        at_pos();
        at_neg();
        chk("busy_after", 32'(busy), 32'd0);
        at_pos();
    endtask

    initial begin
        bit ok;
        bit seen;
        int unsigned base;

        rst_n      = 1'b0;
        req_valid  = '0;
        rsp_ready  = '1;
        stray      = 1'b0;
        keep_valid = 1'b0;
        drop_mask  = '0;
        hs_count   = 0;
        checks     = 0;
        errors     = 0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        vecs[0] = '{2'd0, 32'd100,        32'd7, 32'd14,       32'd2, 38};
        vecs[1] = '{2'd2, 32'd5,          32'd0, 32'hFFFFFFFF, 32'd5, 4};
        vecs[2] = '{2'd3, 32'd0,          32'd9, 32'd0,        32'd0, 38};
        vecs[3] = '{2'd0, 32'hFFFFFFFF,   32'd1, 32'hFFFFFFFF, 32'd0, 38};
        vecs[4] = '{2'd1, 32'd7,          32'd9, 32'd0,        32'd7, 38};
        last_vec = '{2'd2, 32'd123456789, 32'd1000, 32'd123456, 32'd789, 38};

        // Reset state
        repeat (2) begin at_neg(); at_pos(); end
        at_neg();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_div_dividend", div_dividend, 32'd0);
        chk("rst_rsp_quotient", rsp_quotient, 32'd0);
        at_pos();
        rst_n = 1'b1;
        at_neg();
        at_pos();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during WAIT discards the operation; ptr was 2 before it
        op_a[2] = 32'd77;
        op_b[2] = 32'd4;
        req_valid[2] = 1'b1;
        wait_grant(2'd2, ok);
        chk("rstw_grant", 32'(ok), 32'd1);
        at_pos();
        repeat (19) begin at_neg(); at_pos(); end
        rst_n = 1'b0;
        at_neg();
        chk("rstw_req_ready", 32'(req_ready), 32'd0);
        chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        at_pos();
        at_neg();
        chk("rstw_div_start", 32'(div_start), 32'd0);
        chk("rstw_div_dividend", div_dividend, 32'd0);
        chk("rstw_div_divisor", div_divisor, 32'd0);
        chk("rstw_rsp_quotient", rsp_quotient, 32'd0);
        chk("rstw_rsp_remainder", rsp_remainder, 32'd0);
        at_pos();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (45) begin
            at_neg();
            if (rsp_valid != '0 || busy) seen = 1'b1;
            at_pos();
        end
        chk("rstw_quiet", 32'(seen), 32'd0);

        // ptr back at 0: requester 1 must win over 3
        op_a[1] = 32'd300; op_b[1] = 32'd7;
        op_a[3] = 32'd300; op_b[3] = 32'd11;
        sb.push_back('{2'd1, 32'd42, 32'd6});
        sb.push_back('{2'd3, 32'd27, 32'd3});
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        drain(300);

        // Fairness: all held valid, expect 0,1,2,3,0
        op_a[0] = 32'd1000; op_b[0] = 32'd3;
        op_a[1] = 32'd1000; op_b[1] = 32'd7;
        op_a[2] = 32'd1000; op_b[2] = 32'd9;
        op_a[3] = 32'd1000; op_b[3] = 32'd11;
        sb.push_back('{2'd0, 32'd333, 32'd1});
        sb.push_back('{2'd1, 32'd142, 32'd6});
        sb.push_back('{2'd2, 32'd111, 32'd1});
        sb.push_back('{2'd3, 32'd90,  32'd10});
        sb.push_back('{2'd0, 32'd333, 32'd1});
        keep_valid = 1'b1;
        base = hs_count;
        req_valid = '1;
        for (int k = 0; k < 400; k++) begin
            at_neg();
            at_pos();
            if (hs_count - base >= 5) break;
        end
        req_valid  = '0;
        keep_valid = 1'b0;
        chk("fair_grants", hs_count - base, 32'd5);
        drain(200);

        // Backpressure on requester 1 with requester 3 waiting, stray done in RESP
        rsp_ready[1] = 1'b0;
        op_a[1] = 32'hFFFFFFFF; op_b[1] = 32'h10;
        op_a[3] = 32'd50;       op_b[3] = 32'd5;
        sb.push_back('{2'd1, 32'h0FFFFFFF, 32'hF});
        sb.push_back('{2'd3, 32'd10, 32'd0});
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            at_neg();
            if (rsp_valid[1]) begin
                ok = 1'b1;
                break;
            end
            at_pos();
        end
        chk("bp_rsp_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 10; i++) begin
            at_pos();
            stray = (i == 3 || i == 4);
            at_neg();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("bp_quotient", rsp_quotient, 32'h0FFFFFFF);
            chk("bp_remainder", rsp_remainder, 32'hF);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        at_pos();
        stray = 1'b0;
        rsp_ready[1] = 1'b1;
        drain(200);

        // Stray done while idle
        stray = 1'b1;
        repeat (3) begin
            at_neg();
            chk("stray_idle_busy", 32'(busy), 32'd0);
            chk("stray_idle_rsp", 32'(rsp_valid), 32'd0);
            at_pos();
        end
        stray = 1'b0;
        run_vec(last_vec);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
